// File: rtl/sdram_fsm_pkg.sv
// Shared definitions for the SDRAM controller control path.
// Holds the 5-bit init/work state encodings (common with the timing block),
// the {ras_n,cas_n,we_n} command encodings, default geometry and the mode
// register value, plus helpers that map a destination state to its command.
package sdram_fsm_pkg;

    localparam int          ROW_W_DEF = 13;
    localparam int          COL_W_DEF = 9;
    localparam int          BA_W_DEF  = 2;
    localparam int          DQ_W_DEF  = 16;
    // CL=3, BL=8, sequential burst
    localparam logic [12:0] MODE_REG  = 13'h033;

    // {ras_n, cas_n, we_n}; cs_n is held low by the command register
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_AR  = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;

    typedef enum logic [4:0] {
        I_POWON    = 5'd0,
        I_PRE_TRP  = 5'd1,
        I_AR0_TRFC = 5'd2,
        I_AR1_TRFC = 5'd3,
        I_MRS_TMRD = 5'd4,
        I_DONE     = 5'd5
    } init_state_e;

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_AR      = 5'd1,
        S_TRFC    = 5'd2,
        S_AR1     = 5'd3,
        S_TRFC1   = 5'd4,
        S_TRCD    = 5'd5,
        S_WR_DATA = 5'd6,
        S_TDAL    = 5'd7,
        S_CL      = 5'd8,
        S_RD_DATA = 5'd9,
        S_RWAIT   = 5'd10
    } work_state_e;

    // Command issued when the init FSM enters state s
    function automatic logic [2:0] init_cmd(input init_state_e s);
        logic [2:0] c;
        case (s)
            I_PRE_TRP:              c = CMD_PRE;
            I_AR0_TRFC, I_AR1_TRFC: c = CMD_AR;
            I_MRS_TMRD:             c = CMD_LMR;
            default:                c = CMD_NOP;
        endcase
        return c;
    endfunction

    // Command issued when the work FSM enters state s
    function automatic logic [2:0] work_cmd(input work_state_e s);
        logic [2:0] c;
        case (s)
            S_AR, S_AR1: c = CMD_AR;
            S_TRCD:      c = CMD_ACT;
            S_WR_DATA:   c = CMD_WR;
            S_CL:        c = CMD_RD;
            default:     c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sdram_fsm_if.sv
// User read/write handshake plus SDRAM pad bundle.
// slave  : the controller FSM (takes requests/write data, drives acks and pads)
// master : the user side / environment
interface sdram_fsm_if #(
    parameter int ROW_W = 13,
    parameter int COL_W = 9,
    parameter int BA_W  = 2,
    parameter int DQ_W  = 16
);
    logic                        sdram_wr_req;
    logic                        sdram_rd_req;
    logic [BA_W+ROW_W+COL_W-1:0] sys_addr;
    logic                        sdram_wr_ack;
    logic                        sdram_rd_ack;
    logic                        wr_data_rd;
    logic [DQ_W-1:0]             wr_data;
    logic                        sdram_cke;
    logic                        sdram_cs_n;
    logic                        sdram_ras_n;
    logic                        sdram_cas_n;
    logic                        sdram_we_n;
    logic [BA_W-1:0]             sdram_ba;
    logic [ROW_W-1:0]            sdram_addr;
    logic [DQ_W-1:0]             sdram_dq_out;
    logic                        sdram_dq_oe;

    modport slave (
        input  sdram_wr_req, sdram_rd_req, sys_addr, wr_data,
        output sdram_wr_ack, sdram_rd_ack, wr_data_rd,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output sdram_wr_req, sdram_rd_req, sys_addr, wr_data,
        input  sdram_wr_ack, sdram_rd_ack, wr_data_rd,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_fsm_cmd_reg.sv
// Registered SDRAM command/bank/address decode.
// A command is loaded only on the edge where an FSM changes state, so it is
// present for exactly the first cycle of the destination state; NOP otherwise.
// Ports: clk, rst_n; init_cur/init_nxt, work_cur/work_nxt state pairs;
//        ba_src/row_src/col_src address source; cs_n/ras_n/cas_n/we_n, ba, addr pads.
module sdram_fsm_cmd_reg
    import sdram_fsm_pkg::*;
#(
    parameter int ROW_W = 13,
    parameter int COL_W = 9,
    parameter int BA_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  init_state_e      init_cur,
    input  init_state_e      init_nxt,
    input  work_state_e      work_cur,
    input  work_state_e      work_nxt,
    input  logic [BA_W-1:0]  ba_src,
    input  logic [ROW_W-1:0] row_src,
    input  logic [COL_W-1:0] col_src,
    output logic             cs_n,
    output logic             ras_n,
    output logic             cas_n,
    output logic             we_n,
    output logic [BA_W-1:0]  ba,
    output logic [ROW_W-1:0] addr
);

    logic [2:0]       cmd_s;
    logic [BA_W-1:0]  ba_s;
    logic [ROW_W-1:0] addr_s;

    // Decode command/address for the state about to be entered
    always_comb begin
        cmd_s  = CMD_NOP;
        ba_s   = '0;
        addr_s = '0;
        if (init_nxt != init_cur) begin
            cmd_s = init_cmd(init_nxt);
            if (init_nxt == I_PRE_TRP) begin
                addr_s[10] = 1'b1;              // precharge all banks
            end else if (init_nxt == I_MRS_TMRD) begin
                addr_s = ROW_W'(MODE_REG);
            end else begin
                addr_s = '0;
            end
        end else if (work_nxt != work_cur) begin
            cmd_s = work_cmd(work_nxt);
            case (work_nxt)
                S_TRCD: begin
                    ba_s   = ba_src;
                    addr_s = row_src;
                end
                S_WR_DATA, S_CL: begin
                    ba_s               = ba_src;
                    addr_s[10]         = 1'b1;   // auto-precharge
                    addr_s[COL_W-1:0]  = col_src;
                end
                default: begin
                    ba_s   = '0;
                    addr_s = '0;
                end
            endcase
        end else begin
            cmd_s = CMD_NOP;
        end
    end

    // Command pad registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n  <= 1'b0;
            ras_n <= 1'b1;
            cas_n <= 1'b1;
            we_n  <= 1'b1;
            ba    <= '0;
            addr  <= '0;
        end else begin
            cs_n                 <= 1'b0;
            {ras_n, cas_n, we_n} <= cmd_s;
            ba                   <= ba_s;
            addr                 <= addr_s;
        end
    end

endmodule

// File: rtl/sdram_fsm.sv
// SDRAM controller init + work state machines.
// Ports: clk, rst_n; done_200us and end_* timing flags, sdram_ref_req in;
//        sdram_ref_ack, init_state/work_state and their 1-clk delayed cur_* copies out;
//        bus (slave): user wr/rd handshake, write data and SDRAM pads.
module sdram_fsm
    import sdram_fsm_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int BA_W  = BA_W_DEF,
    parameter int DQ_W  = DQ_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done_200us,
    input  logic        end_trp,
    input  logic        end_trfc,
    input  logic        end_tmrd,
    input  logic        end_trcd,
    input  logic        end_tcl,
    input  logic        end_tread,
    input  logic        end_twait,
    input  logic        end_twrite,
    input  logic        end_tdal,
    input  logic        sdram_ref_req,
    output logic        sdram_ref_ack,
    output logic [4:0]  init_state,
    output logic [4:0]  work_state,
    output logic [4:0]  cur_init_state,
    output logic [4:0]  cur_work_state,
    sdram_fsm_if.slave  bus
);

    localparam int AW = BA_W + ROW_W + COL_W;

    init_state_e      init_r, init_nxt_s;
    work_state_e      work_r, work_nxt_s;
    logic [4:0]       cur_init_r, cur_work_r;
    logic             op_wr_r;
    logic [BA_W-1:0]  ba_r, ba_src_s;
    logic [ROW_W-1:0] row_r, row_src_s;
    logic [COL_W-1:0] col_r, col_src_s;
    logic             ref_ack_r, wr_ack_r, rd_ack_r, dq_oe_r, cke_r;
    logic             idle_s, acc_ref_s, acc_wr_s, acc_rd_s;

    // Work FSM only arbitrates once init is complete; ref > wr > rd
    assign idle_s    = (work_r == S_IDLE) && (init_r == I_DONE);
    assign acc_ref_s = idle_s && sdram_ref_req;
    assign acc_wr_s  = idle_s && !sdram_ref_req && bus.sdram_wr_req;
    assign acc_rd_s  = idle_s && !sdram_ref_req && !bus.sdram_wr_req && bus.sdram_rd_req;

    // Init FSM next state
    always_comb begin
        init_nxt_s = init_r;
        case (init_r)
            I_POWON:    if (done_200us) init_nxt_s = I_PRE_TRP;  else init_nxt_s = I_POWON;
            I_PRE_TRP:  if (end_trp)    init_nxt_s = I_AR0_TRFC; else init_nxt_s = I_PRE_TRP;
            I_AR0_TRFC: if (end_trfc)   init_nxt_s = I_AR1_TRFC; else init_nxt_s = I_AR0_TRFC;
            I_AR1_TRFC: if (end_trfc)   init_nxt_s = I_MRS_TMRD; else init_nxt_s = I_AR1_TRFC;
            I_MRS_TMRD: if (end_tmrd)   init_nxt_s = I_DONE;     else init_nxt_s = I_MRS_TMRD;
            I_DONE:     init_nxt_s = I_DONE;
            default:    init_nxt_s = I_POWON;
        endcase
    end

    // Work FSM next state
    always_comb begin
        work_nxt_s = work_r;
        case (work_r)
            S_IDLE: begin
                if (acc_ref_s)                 work_nxt_s = S_AR;
                else if (acc_wr_s || acc_rd_s) work_nxt_s = S_TRCD;
                else                           work_nxt_s = S_IDLE;
            end
            S_AR:      work_nxt_s = S_TRFC;
            S_TRFC:    if (end_trfc)   work_nxt_s = S_AR1;     else work_nxt_s = S_TRFC;
            S_AR1:     work_nxt_s = S_TRFC1;
            S_TRFC1:   if (end_trfc)   work_nxt_s = S_IDLE;    else work_nxt_s = S_TRFC1;
            S_TRCD: begin
                if (end_trcd) work_nxt_s = op_wr_r ? S_WR_DATA : S_CL;
                else          work_nxt_s = S_TRCD;
            end
            S_WR_DATA: if (end_twrite) work_nxt_s = S_TDAL;    else work_nxt_s = S_WR_DATA;
            S_TDAL:    if (end_tdal)   work_nxt_s = S_IDLE;    else work_nxt_s = S_TDAL;
            S_CL:      if (end_tcl)    work_nxt_s = S_RD_DATA; else work_nxt_s = S_CL;
            S_RD_DATA: if (end_tread)  work_nxt_s = S_RWAIT;   else work_nxt_s = S_RD_DATA;
            S_RWAIT:   if (end_twait)  work_nxt_s = S_IDLE;    else work_nxt_s = S_RWAIT;
            default:   work_nxt_s = S_IDLE;
        endcase
    end

    // ACTIVE is issued on the accept edge, before the latch holds the address
    always_comb begin
        if (work_r == S_IDLE) begin
            ba_src_s  = bus.sys_addr[AW-1 -: BA_W];
            row_src_s = bus.sys_addr[ROW_W+COL_W-1 -: ROW_W];
            col_src_s = bus.sys_addr[COL_W-1:0];
        end else begin
            ba_src_s  = ba_r;
            row_src_s = row_r;
            col_src_s = col_r;
        end
    end

    // State registers, request latch and handshake/strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_r     <= I_POWON;
            work_r     <= S_IDLE;
            cur_init_r <= 5'd0;
            cur_work_r <= 5'd0;
            op_wr_r    <= 1'b0;
            ba_r       <= '0;
            row_r      <= '0;
            col_r      <= '0;
            ref_ack_r  <= 1'b0;
            wr_ack_r   <= 1'b0;
            rd_ack_r   <= 1'b0;
            dq_oe_r    <= 1'b0;
            cke_r      <= 1'b1;
        end else begin
            init_r     <= init_nxt_s;
            work_r     <= work_nxt_s;
            cur_init_r <= init_r;
            cur_work_r <= work_r;
            if (acc_wr_s || acc_rd_s) begin
                op_wr_r <= acc_wr_s;
                ba_r    <= ba_src_s;
                row_r   <= row_src_s;
                col_r   <= col_src_s;
            end
            ref_ack_r  <= acc_ref_s;
            wr_ack_r   <= acc_wr_s;
            rd_ack_r   <= acc_rd_s;
            dq_oe_r    <= (work_nxt_s == S_WR_DATA);
            cke_r      <= 1'b1;
        end
    end

    sdram_fsm_cmd_reg #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .BA_W  (BA_W)
    ) u_cmd_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_cur (init_r),
        .init_nxt (init_nxt_s),
        .work_cur (work_r),
        .work_nxt (work_nxt_s),
        .ba_src   (ba_src_s),
        .row_src  (row_src_s),
        .col_src  (col_src_s),
        .cs_n     (bus.sdram_cs_n),
        .ras_n    (bus.sdram_ras_n),
        .cas_n    (bus.sdram_cas_n),
        .we_n     (bus.sdram_we_n),
        .ba       (bus.sdram_ba),
        .addr     (bus.sdram_addr)
    );

    assign init_state       = init_r;
    assign work_state       = work_r;
    assign cur_init_state   = cur_init_r;
    assign cur_work_state   = cur_work_r;
    assign sdram_ref_ack    = ref_ack_r;
    assign bus.sdram_wr_ack = wr_ack_r;
    assign bus.sdram_rd_ack = rd_ack_r;
    assign bus.wr_data_rd   = dq_oe_r;
    assign bus.sdram_dq_oe  = dq_oe_r;
    assign bus.sdram_cke    = cke_r;
    // FWFT source presents data in the strobe cycle, so pass it straight through
    assign bus.sdram_dq_out = dq_oe_r ? bus.wr_data : '0;

endmodule
